// File: rtl/capture_writer.sv
// Ring-buffer capture front end: writes the ADC stream circularly into RAM port A,
// keeps PRE_TRIG samples of history, captures POST_TRIG samples, then freezes a frame.
module capture_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int PRE_TRIG   = 256,
  parameter int POST_TRIG  = 768
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ARM,
  input  logic                  SAMPLE_VALID,
  input  logic [DATA_WIDTH-1:0] SAMPLE_DATA,
  input  logic                  TRIG,
  input  logic                  FRAME_ACK,
  output logic                  RAM_WE,
  output logic                  RAM_EN,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DIN,
  output logic                  FRAME_READY,
  output logic [ADDR_WIDTH-1:0] FRAME_START,
  output logic [ADDR_WIDTH:0]   FRAME_LEN,
  output logic                  BUSY,
  output logic [15:0]           DROP_CNT,
  output logic [2:0]            state_dbg
);

  if (PRE_TRIG < 1 || POST_TRIG < 1 || PRE_TRIG + POST_TRIG > (1 << ADDR_WIDTH)) begin : g_bad_params
    $fatal(1, "capture_writer: PRE_TRIG/POST_TRIG do not fit the ring");
  end

  localparam logic [ADDR_WIDTH:0]   PRE_LEN  = (ADDR_WIDTH+1)'(PRE_TRIG);
  localparam logic [ADDR_WIDTH:0]   POST_LEN = (ADDR_WIDTH+1)'(POST_TRIG);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PRE_OFS  = ADDR_WIDTH'(PRE_TRIG);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  frame_ready_q, frame_ready_d;
  logic [ADDR_WIDTH-1:0] frame_start_q, frame_start_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  accept;

  // Sample handshake: there is no backpressure. A sample is taken on any edge where
  // SAMPLE_VALID is high and the FSM is in FILL, ARMED or POST; in DONE it is counted as dropped.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    post_cnt_d    = post_cnt_q;
    trig_addr_d   = trig_addr_q;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    frame_start_d = frame_start_q;
    drop_cnt_d    = drop_cnt_q;
    accept        = 1'b0;
    // Delayed one cycle behind DONE so the final post-trigger write is already committed.
    frame_ready_d = (state_q == S_DONE) && !FRAME_ACK;

    case (state_q)
      S_IDLE: begin
        if (ARM) begin
          state_d    = S_FILL;
          wr_ptr_d   = '0;
          fill_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (SAMPLE_VALID) begin
          accept     = 1'b1;
          fill_cnt_d = fill_cnt_q + CNT_ONE;
          if (fill_cnt_d == PRE_LEN) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (SAMPLE_VALID) begin
          accept = 1'b1;
          if (TRIG) begin
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = CNT_ONE;
            state_d     = (POST_TRIG == 1) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (SAMPLE_VALID) begin
          accept     = 1'b1;
          post_cnt_d = post_cnt_q + CNT_ONE;
          if (post_cnt_d == POST_LEN) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (SAMPLE_VALID && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        if (FRAME_ACK) begin
          if (ARM) begin
            state_d    = S_FILL;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      ram_we_d   = 1'b1;
      ram_addr_d = wr_ptr_q;
      ram_din_d  = SAMPLE_DATA;
      wr_ptr_d   = wr_ptr_q + ADDR_ONE;
    end

    if (state_d == S_DONE && state_q != S_DONE) frame_start_d = trig_addr_d - PRE_OFS;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      post_cnt_q    <= '0;
      trig_addr_q   <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      frame_ready_q <= 1'b0;
      frame_start_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_cnt_q    <= fill_cnt_d;
      post_cnt_q    <= post_cnt_d;
      trig_addr_q   <= trig_addr_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      frame_ready_q <= frame_ready_d;
      frame_start_q <= frame_start_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign RAM_WE      = ram_we_q;
  assign RAM_EN      = ram_we_q;
  assign RAM_ADDR    = ram_addr_q;
  assign RAM_DIN     = ram_din_q;
  assign FRAME_READY = frame_ready_q;
  assign FRAME_START = frame_start_q;
  assign FRAME_LEN   = (ADDR_WIDTH+1)'(PRE_TRIG + POST_TRIG);
  assign BUSY        = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
  assign DROP_CNT    = drop_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_capture_writer.sv
// Directed bench for capture_writer: a cycle model predicts every RAM write and status output;
// expected writes go through a queue and are popped when the RAM port shows them.
module tb_capture_writer;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int PRE  = 4;
  localparam int POST = 8;
  localparam int W    = AW + DW;

  logic          CLK;
  logic          RST;
  logic          ARM;
  logic          SAMPLE_VALID;
  logic [DW-1:0] SAMPLE_DATA;
  logic          TRIG;
  logic          FRAME_ACK;
  logic          RAM_WE;
  logic          RAM_EN;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DIN;
  logic          FRAME_READY;
  logic [AW-1:0] FRAME_START;
  logic [AW:0]   FRAME_LEN;
  logic          BUSY;
  logic [15:0]   DROP_CNT;
  logic [2:0]    state_dbg;

  capture_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRE_TRIG(PRE), .POST_TRIG(POST)
  ) dut (
    .CLK(CLK), .RST(RST), .ARM(ARM), .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_DATA(SAMPLE_DATA), .TRIG(TRIG), .FRAME_ACK(FRAME_ACK),
    .RAM_WE(RAM_WE), .RAM_EN(RAM_EN), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
    .FRAME_READY(FRAME_READY), .FRAME_START(FRAME_START), .FRAME_LEN(FRAME_LEN),
    .BUSY(BUSY), .DROP_CNT(DROP_CNT), .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // scoreboard and model
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] mem [16];
  int checks = 0;
  int errors = 0;
  int m_state, m_ptr, m_fill, m_post, m_trig, m_start, m_drop;
  logic m_we, m_fr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    chk("ram_we", {31'd0, RAM_WE}, {31'd0, m_we});
    chk("ram_en", {31'd0, RAM_EN}, {31'd0, m_we});
    if (RAM_WE === 1'b1) begin
      chk("exp_q_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {12'd0, RAM_ADDR, RAM_DIN}, {12'd0, e});
      end
      mem[RAM_ADDR] = RAM_DIN;
    end
    chk("busy", {31'd0, BUSY}, (m_state >= 1 && m_state <= 3) ? 32'd1 : 32'd0);
    chk("frame_ready", {31'd0, FRAME_READY}, {31'd0, m_fr});
    chk("drop_cnt", {16'd0, DROP_CNT}, m_drop);
    chk("state", {29'd0, state_dbg}, m_state);
    if (m_fr) begin
      chk("frame_start", {28'd0, FRAME_START}, m_start);
      chk("frame_len", {27'd0, FRAME_LEN}, PRE + POST);
    end
  endtask

  task automatic accept(input logic [DW-1:0] dat);
    exp_q.push_back({AW'(m_ptr), dat});
    m_we  = 1'b1;
    m_ptr = (m_ptr + 1) % 16;
  endtask

  // driver: one clock of stimulus, model update, then check just after the edge
  task automatic step(input logic arm, input logic vld, input logic [DW-1:0] dat,
                      input logic trg, input logic ack);
    int prev;
    @(negedge CLK);
    RST = 1'b0; ARM = arm; SAMPLE_VALID = vld; SAMPLE_DATA = dat; TRIG = trg; FRAME_ACK = ack;
    prev = m_state;
    m_we = 1'b0;
    case (m_state)
      0: if (arm) begin m_state = 1; m_ptr = 0; m_fill = 0; end
      1: if (vld) begin
           accept(dat); m_fill++;
           if (m_fill == PRE) m_state = 2;
         end
      2: if (vld) begin
           if (trg) begin m_trig = m_ptr; m_post = 1; m_state = (POST == 1) ? 4 : 3; end
           accept(dat);
         end
      3: if (vld) begin
           accept(dat); m_post++;
           if (m_post == POST) m_state = 4;
         end
      default: begin
        if (vld && m_drop < 65535) m_drop++;
        if (ack) begin
          if (arm) begin m_state = 1; m_ptr = 0; m_fill = 0; end
          else m_state = 0;
        end
      end
    endcase
    if (m_state == 4 && prev != 4) m_start = (m_trig - PRE) & 15;
    m_fr = (prev == 4) && !ack;
    @(posedge CLK); #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; ARM = 1'b0; SAMPLE_VALID = 1'b0; SAMPLE_DATA = '0; TRIG = 1'b0; FRAME_ACK = 1'b0;
    m_state = 0; m_ptr = 0; m_fill = 0; m_post = 0; m_we = 1'b0; m_fr = 1'b0; m_drop = 0; m_start = 0;
    @(posedge CLK); #1;
    chk("rst_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    chk("rst_ram_addr", {28'd0, RAM_ADDR}, 0);
    chk("rst_ram_din", {16'd0, RAM_DIN}, 0);
    chk("rst_frame_start", {28'd0, FRAME_START}, 0);
    check_outputs();
  endtask

  // ARM, then a ramp until the model reaches DONE (bounded)
  task automatic run_capture(input logic [31:0] trig_mask, input bit toggle, input bit arm_noise);
    int s;
    logic v, t, a;
    s = 0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 100 && m_state != 4; c++) begin
      v = toggle ? (c % 2 == 0) : 1'b1;
      t = v && (s < 32) && trig_mask[s % 32];
      a = arm_noise && (m_state == 2 || m_state == 3) && (c % 3 == 0);
      step(a, v, DW'(s), t, 1'b0);
      if (v) s++;
    end
    chk("capture_done", {29'd0, state_dbg}, 4);
  endtask

  initial begin
    RST = 1'b1; ARM = 1'b0; SAMPLE_VALID = 1'b0; SAMPLE_DATA = '0; TRIG = 1'b0; FRAME_ACK = 1'b0;

    // 1: trigger on sample 9, wrap through address 0
    do_reset();
    run_capture(32'h0000_0200, 1'b0, 1'b0);
    chk("s1_last_write_we", {31'd0, RAM_WE}, 1);
    chk("s1_last_write_addr", {28'd0, RAM_ADDR}, 0);
    chk("s1_ready_not_yet", {31'd0, FRAME_READY}, 0);
    step(1'b0, 1'b1, 16'd17, 1'b0, 1'b0);
    chk("s1_ready_rise", {31'd0, FRAME_READY}, 1);
    chk("s1_frame_start", {28'd0, FRAME_START}, 5);
    chk("s1_frame_len", {27'd0, FRAME_LEN}, 12);
    for (int i = 0; i < 12; i++) chk("s1_portb_read", {16'd0, mem[(5 + i) % 16]}, 5 + i);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("s1_ready_fall", {31'd0, FRAME_READY}, 0);

    // 2: triggers during FILL are ignored
    do_reset();
    run_capture(32'h0000_004E, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("s2_frame_start", {28'd0, FRAME_START}, 2);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // 3: gapped samples, trigger on valid sample 5
    do_reset();
    run_capture(32'h0000_0020, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("s3_frame_start", {28'd0, FRAME_START}, 1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // 4: drops in DONE, ARM alone ignored, ACK+ARM restarts at address 0
    do_reset();
    run_capture(32'h0000_0200, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, DW'(100 + i), 1'b0, 1'b0);
    chk("s4_drop_cnt", {16'd0, DROP_CNT}, 20);
    chk("s4_no_write", {31'd0, RAM_WE}, 0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("s4_arm_ignored", {29'd0, state_dbg}, 4);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("s4_refill_state", {29'd0, state_dbg}, 1);
    chk("s4_refill_busy", {31'd0, BUSY}, 1);
    step(1'b0, 1'b1, 16'd55, 1'b0, 1'b0);
    chk("s4_restart_addr", {28'd0, RAM_ADDR}, 0);
    chk("s4_restart_din", {16'd0, RAM_DIN}, 55);

    // 5: reset in POST after three post-trigger samples
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int s = 0; s < 12; s++) step(1'b0, 1'b1, DW'(s), s == 9, 1'b0);
    chk("s5_in_post", {29'd0, state_dbg}, 3);
    do_reset();
    chk("s5_idle", {29'd0, state_dbg}, 0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd77, 1'b0, 1'b0);
    chk("s5_restart_addr", {28'd0, RAM_ADDR}, 0);

    // 6: ARM pulses in ARMED/POST change nothing
    do_reset();
    run_capture(32'h0000_0200, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("s6_frame_start", {28'd0, FRAME_START}, 5);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
